// File: rtl/telemetry_framer_if.sv
// Byte handshake between the telemetry framer and the serial_tx byte transmitter.
interface telemetry_framer_if;
  logic [7:0] data_tx;
  logic       new_data_tx;
  logic       tx_busy;
  logic       tx_block;

  modport master (
    output data_tx,
    output new_data_tx,
    input  tx_busy,
    input  tx_block
  );

  modport slave (
    input  data_tx,
    input  new_data_tx,
    output tx_busy,
    output tx_block
  );
endinterface

// File: rtl/telemetry_framer.sv
// Snapshots altimeter/gyro fields into a 19-byte frame and streams it to serial_tx,
// started by an external trigger or an internal periodic tick.
module telemetry_framer #(
  parameter int PERIOD_CYCLES = 500000,
  parameter int PERIOD_W      = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trigger,
  input  logic                 clr_overrun,
  input  logic [19:0]          pressure,
  input  logic [19:0]          temp,
  input  logic [19:0]          roll,
  input  logic [19:0]          pitch,
  input  logic [19:0]          yaw,
  telemetry_framer_if.master   tx,
  output logic                 frame_active,
  output logic                 overrun,
  output logic [7:0]           seq
);

  localparam logic [PERIOD_W-1:0] PERIOD_LAST =
    (PERIOD_CYCLES > 0) ? PERIOD_W'(PERIOD_CYCLES - 1) : '0;
  localparam logic [4:0] LAST_IDX = 5'd18;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, WAIT} state_t;

  state_t            state;
  logic [PERIOD_W-1:0] period_cnt;
  logic              tick;
  logic              request;
  logic [4:0]        byte_idx;
  logic [7:0]        cur_byte;
  logic [7:0]        csum;
  logic [7:0]        snap_seq;
  logic [19:0]       snap_pressure;
  logic [19:0]       snap_temp;
  logic [19:0]       snap_roll;
  logic [19:0]       snap_pitch;
  logic [19:0]       snap_yaw;

  // Free-running period counter; held at zero when periodic requests are disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
    end else if ((PERIOD_CYCLES == 0) || (period_cnt == PERIOD_LAST)) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PERIOD_W'(1);
    end
  end

  assign tick    = (PERIOD_CYCLES != 0) && (period_cnt == PERIOD_LAST);
  assign request = trigger | tick;

  always_comb begin
    cur_byte = 8'h00;
    case (byte_idx)
      5'd0:    cur_byte = 8'hA5;
      5'd1:    cur_byte = 8'h5A;
      5'd2:    cur_byte = snap_seq;
      5'd3:    cur_byte = {4'h0, snap_pressure[19:16]};
      5'd4:    cur_byte = snap_pressure[15:8];
      5'd5:    cur_byte = snap_pressure[7:0];
      5'd6:    cur_byte = {4'h0, snap_temp[19:16]};
      5'd7:    cur_byte = snap_temp[15:8];
      5'd8:    cur_byte = snap_temp[7:0];
      5'd9:    cur_byte = {4'h0, snap_roll[19:16]};
      5'd10:   cur_byte = snap_roll[15:8];
      5'd11:   cur_byte = snap_roll[7:0];
      5'd12:   cur_byte = {4'h0, snap_pitch[19:16]};
      5'd13:   cur_byte = snap_pitch[15:8];
      5'd14:   cur_byte = snap_pitch[7:0];
      5'd15:   cur_byte = {4'h0, snap_yaw[19:16]};
      5'd16:   cur_byte = snap_yaw[15:8];
      5'd17:   cur_byte = snap_yaw[7:0];
      5'd18:   cur_byte = csum;
      default: cur_byte = 8'h00;
    endcase
  end

  // HOLD masks tx_busy for one cycle because serial_tx raises busy a cycle after the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      tx.data_tx     <= 8'h00;
      tx.new_data_tx <= 1'b0;
      frame_active   <= 1'b0;
      overrun        <= 1'b0;
      seq            <= 8'h00;
      byte_idx       <= 5'd0;
      csum           <= 8'h00;
      snap_seq       <= 8'h00;
      snap_pressure  <= '0;
      snap_temp      <= '0;
      snap_roll      <= '0;
      snap_pitch     <= '0;
      snap_yaw       <= '0;
    end else begin
      tx.new_data_tx <= 1'b0;

      if (request && frame_active) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (request) begin
            snap_seq      <= seq;
            snap_pressure <= pressure;
            snap_temp     <= temp;
            snap_roll     <= roll;
            snap_pitch    <= pitch;
            snap_yaw      <= yaw;
            csum          <= 8'h00;
            byte_idx      <= 5'd0;
            frame_active  <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (!tx.tx_busy && !tx.tx_block) begin
            tx.data_tx     <= cur_byte;
            tx.new_data_tx <= 1'b1;
            if ((byte_idx >= 5'd2) && (byte_idx <= 5'd17)) begin
              csum <= csum + cur_byte;
            end
            state <= HOLD;
          end
        end
        HOLD: begin
          state <= WAIT;
        end
        WAIT: begin
          if (!tx.tx_busy) begin
            if (byte_idx == LAST_IDX) begin
              seq          <= seq + 8'd1;
              frame_active <= 1'b0;
              state        <= IDLE;
            end else begin
              byte_idx <= byte_idx + 5'd1;
              state    <= ISSUE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer: one triggered instance with a slow serial_tx model
// and one periodic instance with a fast serial_tx model.
module tb_telemetry_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_p;
  logic        trigger;
  logic        clr_overrun;
  logic [19:0] pressure, temp, roll, pitch, yaw;
  logic        frame_active, overrun;
  logic [7:0]  seq;
  logic        frame_active_p, overrun_p;
  logic [7:0]  seq_p;
  logic        zero_bit = 1'b0;
  logic [19:0] zero_field = 20'h0;

  int          compared = 0;
  int          mismatched = 0;
  int          cycle = 0;
  int          busy_len = 10;
  int          busy_cnt, busy_cnt_p;
  int          consec_err = 0;
  int          strobes_in_block = 0;
  logic        block_window = 1'b0;
  logic        prev_strobe = 1'b0;
  logic [7:0]  got [$];
  logic [7:0]  exp_frame [19];

  telemetry_framer_if bus ();
  telemetry_framer_if bus_p ();

  telemetry_framer #(.PERIOD_CYCLES(0), .PERIOD_W(8)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .clr_overrun(clr_overrun),
    .pressure(pressure), .temp(temp), .roll(roll), .pitch(pitch), .yaw(yaw),
    .tx(bus), .frame_active(frame_active), .overrun(overrun), .seq(seq)
  );

  telemetry_framer #(.PERIOD_CYCLES(100), .PERIOD_W(8)) dut_p (
    .clk(clk), .rst(rst_p), .trigger(zero_bit), .clr_overrun(zero_bit),
    .pressure(zero_field), .temp(zero_field), .roll(zero_field), .pitch(zero_field),
    .yaw(zero_field), .tx(bus_p), .frame_active(frame_active_p), .overrun(overrun_p),
    .seq(seq_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // serial_tx models: busy rises the cycle after a strobe and stays high busy_len cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.tx_busy <= 1'b0;
      busy_cnt    <= 0;
    end else if (bus.new_data_tx) begin
      bus.tx_busy <= 1'b1;
      busy_cnt    <= busy_len - 1;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      bus.tx_busy <= 1'b0;
    end
  end

  always @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      bus_p.tx_busy <= 1'b0;
      busy_cnt_p    <= 0;
    end else if (bus_p.new_data_tx) begin
      bus_p.tx_busy <= 1'b1;
      busy_cnt_p    <= 0;
    end else begin
      bus_p.tx_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (bus.new_data_tx) begin
      got.push_back(bus.data_tx);
      if (prev_strobe) consec_err++;
      if (block_window) strobes_in_block++;
    end
    prev_strobe = bus.new_data_tx;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [19:0] p, input logic [19:0] t,
                               input logic [19:0] r, input logic [19:0] pi,
                               input logic [19:0] y);
    pressure = p; temp = t; roll = r; pitch = pi; yaw = y;
    trigger = 1'b1;
    nextCycle();
    trigger = 1'b0;
  endtask

  task automatic waitBytes(input int n, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (got.size() >= n) break;
      nextCycle();
    end
    checkOutput($sformatf("wait_bytes%0d", n), 32'(got.size() >= n), 32'd1);
  endtask

  task automatic waitFrame(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      nextCycle();
      if (got.size() >= 19 && !frame_active) break;
    end
    checkOutput("frame_done", 32'(got.size() >= 19 && !frame_active), 32'd1);
  endtask

  task automatic checkFrame(input string name);
    logic [31:0] obs;
    checkOutput({name, "_len"}, 32'(got.size()), 32'd19);
    for (int i = 0; i < 19; i++) begin
      obs = (i < got.size()) ? {24'h0, got[i]} : 32'h100;
      checkOutput($sformatf("%s_byte%0d", name, i), obs, {24'h0, exp_frame[i]});
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic fa_last;
    logic rose;
    int   c_prev;
    int   k;

    rst = 1'b1; rst_p = 1'b1;
    trigger = 1'b0; clr_overrun = 1'b0;
    pressure = '0; temp = '0; roll = '0; pitch = '0; yaw = '0;
    bus.tx_block = 1'b0; bus_p.tx_block = 1'b0;
    repeat (3) nextCycle();

    checkOutput("rst_data_tx", {24'h0, bus.data_tx}, 32'h0);
    checkOutput("rst_new_data", {31'h0, bus.new_data_tx}, 32'h0);
    checkOutput("rst_frame_active", {31'h0, frame_active}, 32'h0);
    checkOutput("rst_overrun", {31'h0, overrun}, 32'h0);
    checkOutput("rst_seq", {24'h0, seq}, 32'h0);

    // Periodic instance: a frame every 100 cycles, 256 frames to wrap seq.
    rst = 1'b0; rst_p = 1'b0;
    c_prev = cycle;
    fa_last = 1'b0;
    for (int f = 0; f < 256; f++) begin
      rose = 1'b0;
      for (k = 0; k < 300; k++) begin
        nextCycle();
        rose = frame_active_p && !fa_last;
        fa_last = frame_active_p;
        if (rose) break;
      end
      checkOutput($sformatf("period_start%0d", f), {31'h0, rose}, 32'h1);
      checkOutput($sformatf("period_gap%0d", f), 32'(cycle - c_prev), 32'd100);
      checkOutput($sformatf("period_seq%0d", f), {24'h0, seq_p}, 32'(f % 256));
      c_prev = cycle;
    end
    for (k = 0; k < 300 && frame_active_p; k++) nextCycle();
    checkOutput("period_seq_wrap", {24'h0, seq_p}, 32'h0);
    checkOutput("period_overrun", {31'h0, overrun_p}, 32'h0);
    rst_p = 1'b1;

    // Frame 1: all-zero fields, seq 0.
    got.delete();
    applyStimulus(20'h0, 20'h0, 20'h0, 20'h0, 20'h0);
    waitFrame(1000);
    exp_frame = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    checkFrame("zero");
    checkOutput("zero_seq_after", {24'h0, seq}, 32'h1);
    checkOutput("zero_active_after", {31'h0, frame_active}, 32'h0);

    // Frame 2: pressure all ones.
    got.delete();
    applyStimulus(20'hFFFFF, 20'h0, 20'h0, 20'h0, 20'h0);
    waitFrame(1000);
    exp_frame = '{8'hA5, 8'h5A, 8'h01, 8'h0F, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0E};
    checkFrame("press");
    checkOutput("press_seq_after", {24'h0, seq}, 32'h2);

    // Frame 3: mid-frame requests are dropped and flag overrun; inputs change after snapshot.
    got.delete();
    applyStimulus(20'h0, 20'h0, 20'h12345, 20'h0, 20'h0);
    waitBytes(5, 500);
    pressure = 20'h55555; roll = 20'h0; yaw = 20'hFFFFF;
    trigger = 1'b1;
    nextCycle();
    trigger = 1'b0;
    checkOutput("overrun_set", {31'h0, overrun}, 32'h1);
    clr_overrun = 1'b1;
    nextCycle();
    clr_overrun = 1'b0;
    checkOutput("overrun_clear", {31'h0, overrun}, 32'h0);
    trigger = 1'b1; clr_overrun = 1'b1;
    nextCycle();
    trigger = 1'b0; clr_overrun = 1'b0;
    checkOutput("overrun_set_wins", {31'h0, overrun}, 32'h1);
    clr_overrun = 1'b1;
    nextCycle();
    clr_overrun = 1'b0;
    checkOutput("overrun_clear2", {31'h0, overrun}, 32'h0);
    waitFrame(1000);
    exp_frame = '{8'hA5, 8'h5A, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                  8'h23, 8'h45, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h6B};
    checkFrame("roll");
    repeat (5) nextCycle();
    checkOutput("dropped_no_frame", {31'h0, frame_active}, 32'h0);
    checkOutput("roll_seq_after", {24'h0, seq}, 32'h3);

    // Frame 4: tx_block held for 50 cycles after byte 6 was issued.
    got.delete();
    applyStimulus(20'h0, 20'h00001, 20'h0, 20'h0, 20'hABCDE);
    waitBytes(7, 500);
    bus.tx_block = 1'b1;
    strobes_in_block = 0;
    block_window = 1'b1;
    repeat (50) nextCycle();
    block_window = 1'b0;
    bus.tx_block = 1'b0;
    checkOutput("block_no_strobe", 32'(strobes_in_block), 32'd0);
    checkOutput("block_bytes_held", 32'(got.size()), 32'd7);
    waitFrame(1000);
    exp_frame = '{8'hA5, 8'h5A, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hBC, 8'hDE, 8'hA8};
    checkFrame("block");
    checkOutput("block_seq_after", {24'h0, seq}, 32'h4);

    // Frame 5: reset asserted at byte 9, then a fresh complete frame.
    got.delete();
    applyStimulus(20'h0, 20'h0, 20'h0, 20'h80000, 20'h0);
    waitBytes(9, 500);
    rst = 1'b1;
    #1;
    checkOutput("midrst_data_tx", {24'h0, bus.data_tx}, 32'h0);
    checkOutput("midrst_new_data", {31'h0, bus.new_data_tx}, 32'h0);
    checkOutput("midrst_frame_active", {31'h0, frame_active}, 32'h0);
    checkOutput("midrst_seq", {24'h0, seq}, 32'h0);
    repeat (2) nextCycle();
    rst = 1'b0;
    nextCycle();
    got.delete();
    applyStimulus(20'h0, 20'h0, 20'h0, 20'h80000, 20'h0);
    waitFrame(1000);
    exp_frame = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08};
    checkFrame("postrst");
    checkOutput("postrst_seq_after", {24'h0, seq}, 32'h1);

    checkOutput("no_back_to_back", 32'(consec_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
